gcd_controller: RTL and testbench

- FSM controller that sequences the subtract-based GCD datapath.
- Accepts a start request and requests operands A then B on the shared data_in bus.
- Drives the load and select lines from the datapath's gt/lt/eq flags until A==B.
- Reports done or err, each held until acknowledged. Result is left in register A.

---
 rtl/gcd_controller.sv | 192 +++++++++++++++++++
 tb/tb_gcd_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// gcd_controller: sequencing FSM for a subtract-based GCD datapath.
//
// On start it asks the operand source for A, then B, on the shared data_in
// bus. It then repeatedly subtracts the smaller register from the larger
// until the datapath reports A == B. Completion is reported on done and
// failure on err. Each is held until ack. The result is left in register A.
//
// Parameters
//   MAX_ITER  subtract steps allowed before the run is abandoned (< 2**CNT_W)
//   CNT_W     width of the iteration counter
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                run request, sampled only in IDLE
//   ack                  acknowledges done/err, returns to IDLE
//   gt, lt, eq           datapath compare flags (A>B, A<B, A==B)
//   lda, ldb             load register A / B
//   sel1, sel2           subtractor minuend / subtrahend select (0 = A, 1 = B)
//   sel_in               register input select (1 = data_in, 0 = subtractor)
//   req_a, req_b         data_in must carry operand A / B this cycle
//   busy                 run in progress (LOAD_A, LOAD_B, CALC)
//   done, err            result valid / timeout or illegal flags
//   iter_count           subtract count of the last run; present only when
//                        GCD_ITER_COUNT_EN is defined
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start
// LOAD_A | operand A loaded from data_in
// LOAD_B | operand B loaded from data_in
// CALC   | one subtract per cycle until A == B
// DONE   | result valid in A, waiting for ack
// ERR    | timeout or illegal flag combination, waiting for ack

`timescale 1ns/1ps

module gcd_controller #(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ack,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             lda,
    output logic             ldb,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             req_a,
    output logic             req_b,
    output logic             busy,
    output logic             done,
`ifdef GCD_ITER_COUNT_EN
    output logic             err,
    output logic [CNT_W-1:0] iter_count
`else
    output logic             err
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] iter_cnt;
    logic             cnt_clr;
    logic             cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Increments only while below MAX_CNT, so the counter saturates there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if (cnt_clr) begin
            iter_cnt <= '0;
        end else if (cnt_inc) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        lda       = 1'b0;
        ldb       = 1'b0;
        sel1      = 1'b0;
        sel2      = 1'b0;
        sel_in    = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_A;
                    cnt_clr   = 1'b1;
                end
            end
            LOAD_A: begin
                lda       = 1'b1;
                sel_in    = 1'b1;
                req_a     = 1'b1;
                busy      = 1'b1;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                ldb       = 1'b1;
                sel_in    = 1'b1;
                req_b     = 1'b1;
                busy      = 1'b1;
                state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                // Exactly one flag must be high; anything else is a datapath fault.
                case ({gt, lt, eq})
                    3'b001: state_nxt = DONE;
                    3'b100: begin
                        if (iter_cnt < MAX_CNT) begin
                            lda     = 1'b1;
                            sel2    = 1'b1;
                            cnt_inc = 1'b1;
                        end else begin
                            state_nxt = ERR;
                        end
                    end
                    3'b010: begin
                        if (iter_cnt < MAX_CNT) begin
                            ldb     = 1'b1;
                            sel1    = 1'b1;
                            cnt_inc = 1'b1;
                        end else begin
                            state_nxt = ERR;
                        end
                    end
                    default: state_nxt = ERR;
                endcase
            end
            DONE: begin
                done = 1'b1;
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                err = 1'b1;
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef GCD_ITER_COUNT_EN
    // Captures the count as the run leaves CALC. Clears when a new run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_count <= '0;
        end else if (cnt_clr) begin
            iter_count <= '0;
        end else if (state == CALC && (state_nxt == DONE || state_nxt == ERR)) begin
            iter_count <= iter_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_controller.sv
`timescale 1ns/1ps

module tb_gcd_controller;

    localparam int MAX_IT = 8;

    // Output vector order: {lda,ldb,sel1,sel2,sel_in,req_a,req_b,busy,done,err}
    localparam logic [9:0] V_LA   = 10'b1000110100;
    localparam logic [9:0] V_LB   = 10'b0100101100;
    localparam logic [9:0] V_SA   = 10'b1001000100;
    localparam logic [9:0] V_SB   = 10'b0110000100;
    localparam logic [9:0] V_BUSY = 10'b0000000100;
    localparam logic [9:0] V_DONE = 10'b0000000010;
    localparam logic [9:0] V_ERR  = 10'b0000000001;

    logic clk, rst_n, start, ack, gt, lt, eq;
    logic lda, ldb, sel1, sel2, sel_in, req_a, req_b, busy, done, err;
`ifdef GCD_ITER_COUNT_EN
    logic [15:0] iter_count;
`endif

    gcd_controller #(.MAX_ITER(MAX_IT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ack(ack),
        .gt(gt), .lt(lt), .eq(eq),
        .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .req_a(req_a), .req_b(req_b), .busy(busy), .done(done),
`ifdef GCD_ITER_COUNT_EN
        .err(err), .iter_count(iter_count)
`else
        .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath environment: two registers, a subtractor and the flag compare.
    logic [7:0] op_a, op_b, dp_a, dp_b, data_in, sub_out;
    logic       force_bad;
    logic [9:0] dut_vec;

    always_comb begin
        sub_out = (sel1 ? dp_b : dp_a) - (sel2 ? dp_b : dp_a);
        data_in = req_a ? op_a : op_b;
        gt      = force_bad ? 1'b1 : (dp_a > dp_b);
        lt      = force_bad ? 1'b1 : (dp_a < dp_b);
        eq      = force_bad ? 1'b0 : (dp_a == dp_b);
        dut_vec = {lda, ldb, sel1, sel2, sel_in, req_a, req_b, busy, done, err};
    end

    always @(posedge clk) begin
        if (lda) dp_a <= sel_in ? data_in : sub_out;
        if (ldb) dp_b <= sel_in ? data_in : sub_out;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: on an accepted start, the whole run is expanded with
    // plain Euclid-by-subtraction into the per-cycle output sequence.
    logic [9:0] q[$];
    int         term;   // 0 none, 1 done pending/active, 2 err pending/active

    task automatic gen(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b;
        int n;
        a = a_in;
        b = b_in;
        n = 0;
        q.push_back(V_LA);
        q.push_back(V_LB);
        while (a != b && n < MAX_IT) begin
            if (a > b) begin q.push_back(V_SA); a = a - b; end
            else       begin q.push_back(V_SB); b = b - a; end
            n++;
        end
        q.push_back(V_BUSY);
        term = (a == b) ? 1 : 2;
    endtask

    initial begin
        logic [9:0] exp_v;
`ifdef GCD_ITER_COUNT_EN
        logic [15:0] exp_iter, iter_nxt;
        int sub_cnt;
        exp_iter = '0;
        sub_cnt  = 0;
`endif
        term = 0;
        forever begin
            @(negedge clk);
`ifdef GCD_ITER_COUNT_EN
            iter_nxt = exp_iter;
`endif
            if (!rst_n) begin
                exp_v = '0;
                q.delete();
                term = 0;
`ifdef GCD_ITER_COUNT_EN
                exp_iter = '0; iter_nxt = '0; sub_cnt = 0;
`endif
            end else if (force_bad) begin
                exp_v = V_BUSY;
                q.delete();
                term = 2;
`ifdef GCD_ITER_COUNT_EN
                iter_nxt = 16'(sub_cnt);
`endif
            end else if (q.size() > 0) begin
                exp_v = q.pop_front();
`ifdef GCD_ITER_COUNT_EN
                if (exp_v == V_SA || exp_v == V_SB) sub_cnt++;
                if (q.size() == 0) iter_nxt = 16'(sub_cnt);
`endif
            end else if (term != 0) begin
                exp_v = (term == 1) ? V_DONE : V_ERR;
                if (ack) term = 0;
            end else begin
                exp_v = '0;
                if (start) begin
                    gen(op_a, op_b);
`ifdef GCD_ITER_COUNT_EN
                    iter_nxt = '0; sub_cnt = 0;
`endif
                end
            end
            check("outputs", {22'd0, dut_vec}, {22'd0, exp_v});
`ifdef GCD_ITER_COUNT_EN
            check("iter_count", {16'd0, iter_count}, {16'd0, exp_iter});
            exp_iter = iter_nxt;
`endif
        end
    end

    // Stimulus: inputs change 2 ns after the rising edge, outputs are read on
    // the falling edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b);
        tick();
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle index (start cycle = 0) at which done or err appears.
    task automatic wait_end(input bit noise, output int cyc, output int nsub_b);
        bit hit;
        hit    = 1'b0;
        nsub_b = 0;
        cyc    = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done || err) begin hit = 1'b1; break; end
            if (ldb && !sel_in) nsub_b++;
            tick();
            cyc++;
            if (noise && cyc >= 3) start = 1'b1;
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: no done/err within 60 cycles");
        end
    endtask

    task automatic do_ack(input logic with_start);
        tick();
        ack   = 1'b1;
        start = with_start;
        tick();
        ack   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int cyc, nb;
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; force_bad = 1'b0;
        op_a = '0; op_b = '0; dp_a = '0; dp_b = '0;
        #1;
        check("reset_outputs", {22'd0, dut_vec}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 12,18: B=6 then A=6, done at cycle 6
        do_start(8'd12, 8'd18);
        wait_end(1'b0, cyc, nb);
        check("gcd12_18_cycle", cyc, 6);
        check("gcd12_18_result", {24'd0, dp_a}, 6);
        check("gcd12_18_done", {31'd0, done}, 1);
        do_ack(1'b0);
        @(negedge clk);
        check("after_ack_busy", {31'd0, busy}, 0);

        // 7,7: no subtracts, done at cycle 4, ack at cycle 6
        do_start(8'd7, 8'd7);
        wait_end(1'b0, cyc, nb);
        check("gcd7_7_cycle", cyc, 4);
        tick();
        do_ack(1'b0);
        @(negedge clk);
        check("gcd7_7_idle_busy", {31'd0, busy}, 0);

        // 0,5: never converges, 8 ldb subtracts then err
        do_start(8'd0, 8'd5);
        wait_end(1'b0, cyc, nb);
        check("zero_ldb_count", nb, 8);
        check("zero_err", {30'd0, done, err}, 1);
        do_ack(1'b0);

        // illegal flags in the first CALC cycle
        do_start(8'd12, 8'd18);
        tick();
        tick();
        force_bad = 1'b1;
        #1;
        check("bad_flags_no_load", {30'd0, lda, ldb}, 0);
        tick();
        force_bad = 1'b0;
        @(negedge clk);
        check("bad_flags_err", {31'd0, err}, 1);
        do_ack(1'b0);

        // reset in the middle of CALC
        do_start(8'd35, 8'd14);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {22'd0, dut_vec}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 35,14 with start held high through CALC: gcd 7 at cycle 7
        do_start(8'd35, 8'd14);
        wait_end(1'b1, cyc, nb);
        check("gcd35_14_cycle", cyc, 7);
        check("gcd35_14_result", {24'd0, dp_a}, 7);
        do_ack(1'b0);

        // exactly MAX_ITER subtracts still finishes
        do_start(8'd1, 8'd9);
        wait_end(1'b0, cyc, nb);
        check("limit_done_cycle", cyc, 12);
        check("limit_done", {30'd0, done, err}, 2);
        do_ack(1'b0);

        // one subtract too many times out
        do_start(8'd1, 8'd10);
        wait_end(1'b0, cyc, nb);
        check("limit_err_ldb", nb, 8);
        check("limit_err", {30'd0, done, err}, 1);
        do_ack(1'b0);

        // done held for 20 cycles with start toggling, then ack+start together
        do_start(8'd12, 8'd18);
        wait_end(1'b0, cyc, nb);
        for (int i = 0; i < 20; i++) begin
            tick();
            start = i[0];
            @(negedge clk);
            check("hold_done", {29'd0, done, lda, ldb}, 4);
        end
        do_ack(1'b1);
        @(negedge clk);
        check("ack_start_idle", {30'd0, busy, req_a}, 0);
        tick();
        @(negedge clk);
        check("ack_start_no_load", {30'd0, busy, req_a}, 0);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
